// File: rtl/meas_pkg.sv
// Shared measurement-point types used by the channel controller wiring,
// the point capture buffer and the Wishbone register decode.
package meas_pkg;

    localparam int POINT_V_WIDTH   = 16;
    localparam int POINT_T_WIDTH   = 10;
    localparam int POINT_SEQ_WIDTH = 6;

    typedef struct packed {
        logic [POINT_SEQ_WIDTH-1:0] seq;
        logic [POINT_T_WIDTH-1:0]   t;
        logic [POINT_V_WIDTH-1:0]   v;
    } meas_point_t;

endpackage

// File: rtl/fifo_ram_sp.sv
// Simple dual-port RAM: synchronous write, asynchronous read so the FIFO
// head is available in the same cycle (first-word-fall-through).
module fifo_ram_sp #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: one entry per enabled clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/meas_point_buf.sv
// Per-channel capture FIFO: tags each accepted measurement point with a
// wrapping sequence number and holds it until the Wishbone side pops it.
module meas_point_buf
    import meas_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int V_WIDTH        = POINT_V_WIDTH,
    parameter int T_WIDTH        = POINT_T_WIDTH,
    parameter int SEQ_WIDTH      = POINT_SEQ_WIDTH,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      point_rdy_i,
    input  logic [V_WIDTH-1:0]        point_v_i,
    input  logic [T_WIDTH-1:0]        point_t_i,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic                      pop_i,
    output logic [31:0]               rd_data_o,
    output logic                      rd_valid_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      full_o,
    output logic                      ovf_o,
    output logic                      unf_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0]         ADDR_ONE = ADDR_W'(1);
    localparam logic [LVL_W-1:0]          LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]          LVL_FULL = LVL_W'(DEPTH);
    localparam logic [SEQ_WIDTH-1:0]      SEQ_ONE  = SEQ_WIDTH'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

    logic [ADDR_W-1:0]         wr_ptr_r;
    logic [ADDR_W-1:0]         rd_ptr_r;
    logic [LVL_W-1:0]          level_r;
    logic [SEQ_WIDTH-1:0]      seq_r;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;
    logic                      ovf_r;
    logic                      unf_r;

    logic        empty_s;
    logic        full_s;
    logic        push_ok_s;
    logic        pop_ok_s;
    logic        drop_s;
    logic        pop_empty_s;
    logic        ram_we_s;
    logic [31:0] wr_word_s;
    logic [31:0] ram_rd_s;

    // Accept/drop decisions; a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        empty_s     = (level_r == {LVL_W{1'b0}});
        full_s      = (level_r == LVL_FULL);
        pop_ok_s    = 1'b0;
        pop_empty_s = 1'b0;
        push_ok_s   = 1'b0;
        drop_s      = 1'b0;
        if (pop_i) begin
            pop_ok_s    = ~empty_s;
            pop_empty_s = empty_s;
        end else begin
            pop_ok_s    = 1'b0;
            pop_empty_s = 1'b0;
        end
        if (point_rdy_i && en_i) begin
            push_ok_s = ~full_s | pop_ok_s;
            drop_s    = full_s & ~pop_ok_s;
        end else begin
            push_ok_s = 1'b0;
            drop_s    = 1'b0;
        end
        ram_we_s  = push_ok_s & ~clr_i & ~wb_rst_i;
        wr_word_s = {seq_r, point_t_i, point_v_i};
    end

    fifo_ram_sp #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (wr_word_s),
        .raddr (rd_ptr_r),
        .rdata (ram_rd_s)
    );

    // FIFO bookkeeping: reset, then flush, then normal push/pop/drop updates.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_i) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            seq_r      <= {SEQ_WIDTH{1'b0}};
            drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_ONE;
                seq_r    <= seq_r + SEQ_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
                if (drop_cnt_r != DROP_MAX) begin
                    drop_cnt_r <= drop_cnt_r + DROP_ONE;
                end
            end
            if (pop_empty_s) begin
                unf_r <= 1'b1;
            end
        end
    end

    // Memory contents are undefined after reset, so mask the head while empty.
    assign rd_valid_o = ~empty_s;
    assign rd_data_o  = empty_s ? 32'h0000_0000 : ram_rd_s;
    assign level_o    = level_r;
    assign full_o     = full_s;
    assign ovf_o      = ovf_r;
    assign unf_o      = unf_r;
    assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_meas_point_buf.sv
// Directed and randomized checks of meas_point_buf against a queue-based model.
module tb_meas_point_buf;
    import meas_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        point_rdy_i = 1'b0;
    logic [15:0] point_v_i = 16'h0000;
    logic [9:0]  point_t_i = 10'h000;
    logic        en_i = 1'b1;
    logic        clr_i = 1'b0;
    logic        pop_i = 1'b0;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic [6:0]  level_o;
    logic        full_o;
    logic        ovf_o;
    logic        unf_o;
    logic [15:0] drop_cnt_o;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] q[$];
    int          m_seq = 0;
    int          m_drops = 0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    meas_point_buf #(.DEPTH(DEPTH)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .point_rdy_i (point_rdy_i),
        .point_v_i   (point_v_i),
        .point_t_i   (point_t_i),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .pop_i       (pop_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .level_o     (level_o),
        .full_o      (full_o),
        .ovf_o       (ovf_o),
        .unf_o       (unf_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : 32'h0;
        chk("level", 64'(level_o), 64'(q.size()));
        chk("rd_valid", 64'(rd_valid_o), 64'(q.size() != 0));
        chk("full", 64'(full_o), 64'(q.size() == DEPTH));
        chk("rd_data", 64'(rd_data_o), 64'(exp_data));
        chk("ovf", 64'(ovf_o), 64'(m_ovf));
        chk("unf", 64'(unf_o), 64'(m_unf));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));
    endtask

    task automatic model_reset();
        q.delete();
        m_seq = 0;
        m_drops = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic cycle(input bit rdy, input bit en, input logic [15:0] v,
                         input logic [9:0] t, input bit pop, input bit clr);
        bit popped;
        point_rdy_i = rdy;
        en_i        = en;
        point_v_i   = v;
        point_t_i   = t;
        pop_i       = pop;
        clr_i       = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            popped = 1'b0;
            if (pop) begin
                if (q.size() == 0) m_unf = 1'b1;
                else popped = 1'b1;
            end
            if (rdy && en) begin
                if (q.size() == DEPTH && !popped) begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end else begin
                    if (popped) begin
                        void'(q.pop_front());
                        popped = 1'b0;
                    end
                    q.push_back({6'(m_seq), t, v});
                    m_seq = (m_seq + 1) % 64;
                end
            end
            if (popped) void'(q.pop_front());
        end
        #1;
        point_rdy_i = 1'b0;
        pop_i       = 1'b0;
        clr_i       = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        model_reset();
        check_outputs();
    endtask

    task automatic push(input logic [15:0] v, input logic [9:0] t);
        cycle(1'b1, 1'b1, v, t, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 1'b1, 16'h0000, 10'h000, 1'b1, 1'b0);
    endtask

    initial begin
        meas_point_t p;

        // Reset state
        do_reset();

        // Three pushes, then drain in order
        push(16'h1234, 10'h3FF);
        push(16'h0001, 10'h000);
        push(16'hFFFF, 10'h155);
        chk("three_level", 64'(level_o), 64'd3);
        chk("head_seq0", 64'(rd_data_o), 64'h03FF_1234);
        pop();
        chk("head_seq1", 64'(rd_data_o), 64'h0400_0001);
        pop();
        chk("head_seq2", 64'(rd_data_o), 64'h0955_FFFF);
        pop();
        chk("drained_valid", 64'(rd_valid_o), 64'd0);

        // Fill past capacity: five drops
        do_reset();
        for (int i = 0; i < DEPTH + 5; i++) begin
            push(16'($urandom), 10'($urandom));
        end
        chk("full_flag", 64'(full_o), 64'd1);
        chk("full_drops", 64'(drop_cnt_o), 64'd5);

        // Push and pop together while full: accepted, not dropped
        cycle(1'b1, 1'b1, 16'hBEEF, 10'h2AA, 1'b1, 1'b0);
        chk("full_pushpop_level", 64'(level_o), 64'd64);
        chk("full_pushpop_drops", 64'(drop_cnt_o), 64'd5);
        for (int i = 0; i < DEPTH - 1; i++) begin
            p = rd_data_o;
            chk("drain_seq", 64'(p.seq), 64'((i + 1) % 64));
            pop();
        end
        chk("last_entry", 64'(rd_data_o[25:0]), 64'({10'h2AA, 16'hBEEF}));
        pop();

        // Push and pop together on an empty FIFO
        cycle(1'b1, 1'b1, 16'h5A5A, 10'h0F0, 1'b1, 1'b0);
        chk("empty_pushpop_unf", 64'(unf_o), 64'd1);
        chk("empty_pushpop_level", 64'(level_o), 64'd1);

        // 70 pushes with interleaved pops: sequence wraps, no drops
        cycle(1'b0, 1'b1, 16'h0000, 10'h000, 1'b0, 1'b1);
        for (int i = 0; i < 70; i++) begin
            push(16'($urandom), 10'($urandom));
            if (level_o >= 7'd10 || $urandom_range(0, 1) == 1) pop();
        end
        chk("wrap_drops", 64'(drop_cnt_o), 64'd0);

        // Flush with ten entries, overflow set and a concurrent push
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(16'($urandom), 10'($urandom));
        end
        while (level_o > 7'd10) pop();
        cycle(1'b1, 1'b1, 16'h7777, 10'h111, 1'b0, 1'b1);
        chk("clr_level", 64'(level_o), 64'd0);
        chk("clr_ovf", 64'(ovf_o), 64'd0);
        push(16'h4321, 10'h123);
        p = rd_data_o;
        chk("clr_seq", 64'(p.seq), 64'd0);

        // Disabled capture is neither stored nor counted as a drop
        for (int i = 0; i < DEPTH + 3; i++) begin
            cycle(1'b1, (i < DEPTH), 16'($urandom), 10'($urandom), 1'b0, 1'b0);
        end
        chk("en_off_drops", 64'(drop_cnt_o), 64'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                  16'($urandom), 10'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 79) == 0));
        end

        // Reset in the middle of traffic
        push(16'hAAAA, 10'h0AA);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/meas_point_buf.md
Name: meas_point_buf

Overview:
Downstream capture stage for the per-channel measurement controller. It takes each completed measurement point (threshold code + delay code, one-cycle point_rdy pulse), tags it with a wrapping sequence number and stores it in a FIFO. The Wishbone register front-end drains that FIFO to software. One instance per channel, in the wb_clk_i domain next to the controller.

Parameters:
DEPTH, 64, FIFO entries; power of 2, minimum 2
V_WIDTH, 16, threshold (DAC code) width
T_WIDTH, 10, delay-line code width
SEQ_WIDTH, 6, sequence tag width; V_WIDTH+T_WIDTH+SEQ_WIDTH must equal 32
DROP_CNT_WIDTH, 16, dropped-point counter width

Ports:
wb_clk_i  in  1  single clock for the block
wb_rst_i  in  1  reset, synchronous, active-high
point_rdy_i  in  1  one-cycle strobe: point_v_i/point_t_i valid
point_v_i  in  V_WIDTH  threshold code of point
point_t_i  in  T_WIDTH  delay code of point
en_i  in  1  capture enable; point_rdy_i ignored when 0
clr_i  in  1  synchronous flush pulse from a Wishbone write
pop_i  in  1  one-cycle pulse: consume head entry (Wishbone data-register read ack)
rd_data_o  out  32  head entry {seq, t, v}, first-word-fall-through
rd_valid_o  out  1  FIFO not empty; rd_data_o valid
level_o  out  $clog2(DEPTH)+1  current entry count
full_o  out  1  level_o == DEPTH
ovf_o  out  1  sticky: at least one point dropped
unf_o  out  1  sticky: pop_i seen while empty
drop_cnt_o  out  DROP_CNT_WIDTH  dropped points, saturating

Behaviour:
- Reset (wb_rst_i=1 at a clock edge): pointers, level_o, seq counter, drop_cnt_o, ovf_o, unf_o, rd_valid_o, full_o all 0. rd_data_o=0. Memory contents are don't-care.
- Push condition: point_rdy_i & en_i.
  - Entry = {seq, point_t_i, point_v_i}, with v in bits [V_WIDTH-1:0].
  - seq increments by 1 mod 2^SEQ_WIDTH only on an accepted push, and wraps silently.
- Push latency: a push accepted at edge N gives rd_valid_o=1, rd_data_o valid and level_o updated after edge N (visible in cycle N+1).
- Pop: pop_i with rd_valid_o=1 advances the head. The next entry (or rd_valid_o=0) shows after the same edge.
- Full:
  - A push while full and no pop is dropped. Data is not written and seq does not advance.
  - On a drop, ovf_o is set and drop_cnt_o is incremented, saturating at all-ones.
- Simultaneous push+pop:
  - Not empty: both happen; level_o unchanged. This holds when full too, and the push is then accepted, not dropped.
  - Empty: the pop is ignored and unf_o is set. The push is accepted; level_o becomes 1.
- Pop while empty: no pointer change; unf_o set.
- Pointers: wrap modulo DEPTH. level_o is kept explicitly, or as a pointer difference with an extra MSB.
- clr_i priority (highest after reset): empties the FIFO and zeroes seq, drop_cnt_o, ovf_o, unf_o in the same edge. A push or pop in that cycle is discarded.
- en_i:
  - Deassertion does not affect stored data or popping.
  - A point_rdy_i arriving while en_i=0 is not counted as a drop.
- Reset mid-operation: same as the reset case; stored data is lost.
- Outputs are registered or decoded from registered state only. There is no combinational path from point_rdy_i to any output.
- Memory: synchronous write. Head read must satisfy FWFT, either by async read (distributed RAM) or a registered prefetch with correct bypass for the empty→1 case.

Decomposition:
- Package meas_pkg:
  - POINT_V_WIDTH=16, POINT_T_WIDTH=10, POINT_SEQ_WIDTH=6
  - packed struct meas_point_t {seq, t, v}, 32 bits
  - Shared by ch_measure_ctl wiring, this block and the Wishbone register decode.
- Sub-module fifo_ram_sp: simple dual-port RAM, DEPTH x 32, one write port, one read port. This isolates the platform RAM inference.

Test Plan:
- Reset, then 3 pushes v=0x1234/0x0001/0xFFFF, t=0x3FF/0x000/0x155 → rd_data_o after each pop = 0x0_3FF_1234 seq0, seq1 then seq2 words in order; level_o 3→0; rd_valid_o falls after third pop.
- Push to DEPTH=64 then 5 more pushes → full_o=1, level_o=64, ovf_o=1, drop_cnt_o=5. Draining gives 64 entries with seq 0..63 wrapped mod 64, and none of the 5 dropped points.
- At full, assert point_rdy_i and pop_i in the same cycle → level_o stays 64, no drop; last entry read back carries the new v/t.
- Empty FIFO, point_rdy_i and pop_i together → level_o=1, unf_o=1, rd_data_o=pushed point.
- 70 pushes with interleaved pops (level ≤ 10) → seq field wraps 63→0 correctly; drop_cnt_o=0.
- clr_i asserted with 10 entries, ovf_o=1 and a concurrent push → next cycle level_o=0, rd_valid_o=0, ovf_o=0, drop_cnt_o=0; next push gets seq=0.
